// File: rtl/frame_dispatch_pkg.sv
// rtl/frame_dispatch_pkg.sv - shared types and defaults for frame_dispatch
package frame_dispatch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    WRITE  = 2'd2,
    DROP   = 2'd3
  } state_t;

  localparam int DROP_CNT_W     = 16;
  localparam int DEF_ADDR_LSB   = 24;
  localparam int DEF_ADDR_WIDTH = 8;

endpackage

// File: rtl/frame_dispatch_addr_match_enc.sv
// rtl/frame_dispatch_addr_match_enc.sv - lowest-index-wins one-hot encoder for address matches
module addr_match_enc #(
  parameter int N = 5
) (
  input  logic [N-1:0] match,
  output logic [N-1:0] onehot,
  output logic         found
);

  // Two's-complement trick isolates the lowest set bit.
  assign onehot = match & (~match + N'(1));
  assign found  = |match;

endmodule

// File: rtl/frame_dispatch.sv
// rtl/frame_dispatch.sv - routes frames to switch FIFOs by address; FRAME_DROP_CNT_EN adds drop_cnt
module frame_dispatch
  import frame_dispatch_pkg::*;
#(
  parameter int NUM_SW_INST = 5,
  parameter int FRAME_WIDTH = 32,
  parameter int ADDR_LSB    = DEF_ADDR_LSB,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [FRAME_WIDTH-1:0]            frame_in,
  input  logic                              frame_valid_in,
  output logic                              frame_ready_out,
  input  logic [NUM_SW_INST*ADDR_WIDTH-1:0] sw_addr_cfg,
  input  logic [NUM_SW_INST-1:0]            fifo_full,
  output logic [NUM_SW_INST-1:0]            wr_sel,
  output logic [FRAME_WIDTH-1:0]            frame_out,
  output logic                              busy
`ifdef FRAME_DROP_CNT_EN
  ,
  output logic [DROP_CNT_W-1:0]             drop_cnt
`endif
);

  state_t                 state;
  logic [NUM_SW_INST-1:0] target;
  logic [NUM_SW_INST-1:0] match;
  logic [NUM_SW_INST-1:0] match_onehot;
  logic                   match_found;

  always_comb begin
    match = '0;
    for (int i = 0; i < NUM_SW_INST; i++) begin
      match[i] = (frame_out[ADDR_LSB +: ADDR_WIDTH] == sw_addr_cfg[i*ADDR_WIDTH +: ADDR_WIDTH]);
    end
  end

  addr_match_enc #(.N(NUM_SW_INST)) u_enc (
    .match  (match),
    .onehot (match_onehot),
    .found  (match_found)
  );

  // Strobe follows fifo_full combinationally so the write lands in the cycle the target frees up.
  assign wr_sel = (rst_n && state == WRITE && (target & fifo_full) == '0) ? target : '0;
  assign frame_ready_out = rst_n && (state == IDLE);
  assign busy            = rst_n && (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      frame_out <= '0;
      target    <= '0;
`ifdef FRAME_DROP_CNT_EN
      drop_cnt  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (frame_valid_in) begin
            frame_out <= frame_in;
            state     <= DECODE;
          end
        end
        DECODE: begin
          target <= match_onehot;
          if (match_found) begin
            state <= WRITE;
          end else begin
            state <= DROP;
`ifdef FRAME_DROP_CNT_EN
            if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
`endif
          end
        end
        WRITE: begin
          if ((target & fifo_full) == '0) state <= IDLE;
        end
        DROP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/frame_dispatch.md
FRAME_DISPATCH -- requirements
Module: frame_dispatch

Interface
REQ-001 Parameter NUM_SW_INST, default 5, number of switch FIFO write ports.
REQ-002 Parameter FRAME_WIDTH, default 32, frame bit width.
REQ-003 Parameter ADDR_LSB, default 24, LSB position of the destination address field in a frame.
REQ-004 Parameter ADDR_WIDTH, default 8, destination address field width.
REQ-005 clk  input  1  sole clock; all logic on rising edge.
REQ-006 rst_n  input  1  reset, synchronous, active-low.
REQ-007 frame_in  input  FRAME_WIDTH  incoming frame.
REQ-008 frame_valid_in  input  1  frame_in valid.
REQ-009 frame_ready_out  output  1  block can accept a frame.
REQ-010 sw_addr_cfg  input  NUM_SW_INST*ADDR_WIDTH  unit address of switch i in slice [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-011 fifo_full  input  NUM_SW_INST  per-switch FIFO full flag.
REQ-012 wr_sel  output  NUM_SW_INST  one-hot FIFO write strobe; bit i writes FIFO i.
REQ-013 frame_out  output  FRAME_WIDTH  frame presented to FIFO write data.
REQ-014 busy  output  1  high whenever the state is not IDLE.
REQ-015 drop_cnt  output  16  count of dropped frames (present only per REQ-031).

Function
REQ-016 The FSM SHALL have states IDLE, DECODE, WRITE and DROP.
REQ-017 IDLE: frame_ready_out=1; on frame_valid_in=1, frame_in SHALL be registered into frame_out and the state SHALL go to DECODE.
REQ-018 DECODE: the address field frame_out[ADDR_LSB +: ADDR_WIDTH] SHALL be compared against every sw_addr_cfg slice, sampled in this cycle only; the match vector SHALL be registered as a one-hot target with the lowest index winning.
REQ-019 DECODE: any match SHALL go to WRITE; no match SHALL go to DROP.
REQ-020 WRITE: if fifo_full[target]=0, wr_sel SHALL equal target for exactly one cycle and the state SHALL go to IDLE; otherwise wr_sel=0 and the state SHALL remain WRITE, re-evaluating fifo_full every cycle, with no timeout.
REQ-021 DROP: the frame SHALL be discarded, wr_sel=0, and the state SHALL go to IDLE next cycle.
REQ-022 frame_ready_out SHALL be 0 in all states except IDLE; minimum accept-to-write latency is 2 cycles, and maximum throughput is 1 frame per 3 cycles.
REQ-023 frame_out SHALL hold stable from capture until the state returns to IDLE.
REQ-024 wr_sel SHALL be zero or one-hot in every cycle and zero outside WRITE.
REQ-025 A full flag on a non-target FIFO SHALL NOT affect the transfer.

Reset
REQ-026 When rst_n=0 at a clock edge: state=IDLE, frame_out=0, wr_sel=0, busy=0, frame_ready_out=0 during the reset cycle, and drop_cnt=0.
REQ-027 Reset asserted in any state SHALL abandon the frame in flight, with no wr_sel pulse and no drop_cnt increment.
REQ-028 frame_ready_out SHALL be 1 in the first cycle after rst_n deasserts.

Configuration
REQ-029 Macro FRAME_DROP_CNT_EN SHALL gate the drop counter.
REQ-030 Without FRAME_DROP_CNT_EN, the drop_cnt port and counter SHALL be absent; DROP behaviour is unchanged.
REQ-031 With FRAME_DROP_CNT_EN, drop_cnt SHALL increment by 1 on each DECODE-to-DROP transition and saturate at 16'hFFFF.

Structure
REQ-032 Package frame_dispatch_pkg SHALL hold the FSM state enum, the drop counter width constant (16) and the default ADDR_LSB and ADDR_WIDTH localparams.
REQ-033 Sub-module addr_match_enc SHALL convert the NUM_SW_INST match vector to a lowest-index-priority one-hot vector plus a match-found bit (combinational).

Verification
REQ-034 sw_addr_cfg={8'h14,8'h13,8'h12,8'h11,8'h10}, frame 32'h12AB_CDEF valid in IDLE, fifo_full=0 -> wr_sel=5'b00100 exactly 2 cycles after accept, frame_out=32'h12AB_CDEF.
REQ-035 Frame address 8'h55 with no matching slice -> no wr_sel pulse, IDLE after DROP, drop_cnt 0->1 (with FRAME_DROP_CNT_EN).
REQ-036 Target switch 3 with fifo_full[3]=1 for 10 cycles -> wr_sel=0 and busy=1 throughout; wr_sel=5'b01000 in the cycle fifo_full[3] falls.
REQ-037 Slices 1 and 3 both set to 8'h20, frame address 8'h20 -> wr_sel=5'b00010.
REQ-038 rst_n=0 for one cycle while in WRITE -> no wr_sel, frame_out=0, frame_ready_out=1 on the following cycle.
REQ-039 With drop_cnt preloaded by 65535 drops, one further unmatched frame -> drop_cnt stays 16'hFFFF.
